// File: rtl/ascon_pt_stream.sv
// rtl/ascon_pt_stream.sv - streaming ASCON plaintext/ciphertext phase engine
// Each block is XORed with the rate, the output beat is emitted, then p^b runs one round per cycle.
module ascon_pt_stream #(
    parameter int RATE   = 64,
    parameter int ROUNDS = 6,
    parameter int LEN_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dec,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [319:0]     state_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RATE-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RATE-1:0]  out_data,
    output logic [7:0]       out_nbytes,
    output logic             busy,
    output logic             done,
    output logic [319:0]     state_out
);
    localparam int B = RATE / 8;
    localparam logic [319:0] PAD0 = {8'h80, 312'h0};

    typedef enum logic [2:0] {IDLE, LOAD, EMIT, PERM, FIN} fsm_t;

    fsm_t             fsm;
    logic [319:0]     s;
    logic [LEN_W-1:0] rem;
    logic [7:0]       n;
    logic             dec_r;
    logic [3:0]       rcnt;
    logic             pad_pend;

    logic [7:0]       n_take;
    logic [RATE-1:0]  mask;
    logic [RATE-1:0]  pad;
    logic [RATE-1:0]  s_r;
    logic [RATE-1:0]  din;
    logic [RATE-1:0]  xo;
    logic [RATE-1:0]  new_r;
    logic [7:0]       ridx;
    logic [7:0]       rc;
    logic [319:0]     perm_s;

    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [319:0] round_fn(input logic [319:0] st, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = st[319:256];
        x1 = st[255:192];
        x2 = st[191:128] ^ {56'h0, c};
        x3 = st[127:64];
        x4 = st[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0 ^ ror(x0, 19) ^ ror(x0, 28),
                x1 ^ ror(x1, 61) ^ ror(x1, 39),
                x2 ^ ror(x2, 1)  ^ ror(x2, 6),
                x3 ^ ror(x3, 10) ^ ror(x3, 17),
                x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
    endfunction

    assign n_take = (rem >= LEN_W'(B)) ? 8'(B) : 8'(rem);
    assign s_r    = s[319 -: RATE];
    assign din    = in_data & mask;
    assign xo     = s_r ^ din;
    // Decrypt: the ciphertext replaces the consumed bytes; tail bytes keep the old rate
    assign new_r  = (dec_r ? (din | (s_r & ~mask)) : xo) ^ pad;
    assign ridx   = 8'(12 - ROUNDS) + {4'h0, rcnt};
    assign rc     = 8'hf0 - ridx * 8'h0f;
    assign perm_s = round_fn(s, rc);

    always_comb begin
        mask = '0;
        pad  = '0;
        for (int i = 0; i < B; i++) begin
            if (8'(i) < n_take) mask[RATE-1-8*i -: 8] = 8'hff;
            if (8'(i) == n_take) pad[RATE-1-8*i -: 8] = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm        <= IDLE;
            s          <= '0;
            rem        <= '0;
            n          <= '0;
            dec_r      <= 1'b0;
            rcnt       <= '0;
            pad_pend   <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_out  <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    rem      <= msg_len;
                    dec_r    <= dec;
                    busy     <= 1'b1;
                    rcnt     <= '0;
                    pad_pend <= 1'b0;
                    if (msg_len == '0) begin
                        s         <= state_in ^ PAD0;
                        state_out <= state_in ^ PAD0;
                        done      <= 1'b1;
                        fsm       <= FIN;
                    end else begin
                        s        <= state_in;
                        in_ready <= 1'b1;
                        fsm      <= LOAD;
                    end
                end
                LOAD: if (in_valid) begin
                    in_ready       <= 1'b0;
                    s[319 -: RATE] <= new_r;
                    rem            <= rem - LEN_W'(n_take);
                    n              <= n_take;
                    out_data       <= xo & mask;
                    out_nbytes     <= n_take;
                    out_valid      <= 1'b1;
                    fsm            <= EMIT;
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (n < 8'(B)) begin
                        state_out <= s;
                        done      <= 1'b1;
                        fsm       <= FIN;
                    end else begin
                        rcnt     <= '0;
                        pad_pend <= (rem == '0);
                        fsm      <= PERM;
                    end
                end
                PERM: begin
                    if (rcnt == 4'(ROUNDS - 1)) begin
                        // A message that ends on a block boundary still owes the empty padded block
                        if (pad_pend) begin
                            s         <= perm_s ^ PAD0;
                            state_out <= perm_s ^ PAD0;
                            done      <= 1'b1;
                            fsm       <= FIN;
                        end else begin
                            s        <= perm_s;
                            in_ready <= 1'b1;
                            fsm      <= LOAD;
                        end
                    end else begin
                        s    <= perm_s;
                        rcnt <= rcnt + 4'd1;
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_pt_stream.sv
// tb/tb_ascon_pt_stream.sv - self-checking bench for ascon_pt_stream (RATE 64/6 rounds and 128/8 rounds)
module tb_ascon_pt_stream;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b, dec, in_valid, out_ready;
    logic [31:0]  msg_len;
    logic [319:0] state_in;
    logic [127:0] in_data;

    logic         in_ready_a, out_valid_a, busy_a, done_a;
    logic [63:0]  out_data_a;
    logic [7:0]   out_nbytes_a;
    logic [319:0] state_out_a;
    logic         in_ready_b, out_valid_b, busy_b, done_b;
    logic [127:0] out_data_b;
    logic [7:0]   out_nbytes_b;
    logic [319:0] state_out_b;

    logic         use_b;
    logic         m_in_ready, m_out_valid, m_done;
    logic [127:0] m_out_data;
    logic [7:0]   m_out_nbytes;

    assign m_in_ready   = use_b ? in_ready_b   : in_ready_a;
    assign m_out_valid  = use_b ? out_valid_b  : out_valid_a;
    assign m_done       = use_b ? done_b       : done_a;
    assign m_out_data   = use_b ? out_data_b   : {out_data_a, 64'h0};
    assign m_out_nbytes = use_b ? out_nbytes_b : out_nbytes_a;

    always #5 clk = ~clk;

    ascon_pt_stream #(.RATE(64), .ROUNDS(6), .LEN_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dec(dec), .msg_len(msg_len),
        .state_in(state_in), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data[127:64]), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_nbytes(out_nbytes_a), .busy(busy_a),
        .done(done_a), .state_out(state_out_a)
    );

    ascon_pt_stream #(.RATE(128), .ROUNDS(8), .LEN_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dec(dec), .msg_len(msg_len),
        .state_in(state_in), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_nbytes(out_nbytes_b), .busy(busy_b),
        .done(done_b), .state_out(state_out_b)
    );

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    localparam logic [319:0] ST64 = {64'h80400c0600000000, 64'h0001020304050607,
        64'h08090a0b0c0d0e0f, 64'h0011223344556677, 64'h8899aabbccddeeff};
    localparam logic [319:0] ST128 = {64'h80800c0800000000, 64'hf0e1d2c3b4a59687,
        64'h7766554433221100, 64'h0123456789abcdef, 64'hfedcba9876543210};

    int           n_checks = 0;
    int           n_fail = 0;
    logic [7:0]   msg [64];
    logic [7:0]   exp_out [64];
    logic [7:0]   ct [64];
    logic [319:0] exp_state;
    logic [319:0] enc_state;
    logic [7:0]   got_out [64];
    int           got_nb [16];
    int           nbeats, done_c, last_out_c;
    bit           tmo, stall_ok, excl_ok, zero_ok;

    function automatic logic [63:0] rr(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] st, input int rounds);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int k = 0; k < 5; k++) x[k] = st[319-64*k -: 64];
        for (int r = 12 - rounds; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                for (int k = 0; k < 5; k++) y[k][b] = v[4-k];
            end
            x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
            x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
            x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
            x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
            x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    task automatic ref_run(input logic [319:0] st, input int len, input bit d, input int bb, input int rounds);
        logic [319:0] s;
        logic [7:0]   c, o;
        int           pos, n;
        s = st;
        pos = 0;
        while (1) begin
            n = (len - pos < bb) ? len - pos : bb;
            for (int i = 0; i < n; i++) begin
                c = msg[pos+i];
                o = s[319-8*i -: 8] ^ c;
                exp_out[pos+i] = o;
                s[319-8*i -: 8] = d ? c : o;
            end
            if (n < bb) begin
                s[319-8*n -: 8] = s[319-8*n -: 8] ^ 8'h80;
                break;
            end
            pos += bb;
            s = ref_perm(s, rounds);
            if (pos == len) begin
                s[319 -: 8] = s[319 -: 8] ^ 8'h80;
                break;
            end
        end
        exp_state = s;
    endtask

    task automatic run_msg(input bit b, input logic [319:0] st, input int len, input bit d,
                           input int stall_beat, input int stall_len);
        int bb, ipos, opos, stalled;
        logic [127:0] snap_d;
        logic [7:0]   snap_n;
        bb = b ? 16 : 8;
        nbeats = 0; done_c = -1; last_out_c = -1; tmo = 1'b1;
        stall_ok = 1'b1; excl_ok = 1'b1; zero_ok = 1'b1;
        ipos = 0; opos = 0; stalled = 0; snap_d = '0; snap_n = '0;
        for (int i = 0; i < 64; i++) got_out[i] = 8'h5a;
        @(negedge clk);
        use_b = b; state_in = st; msg_len = len; dec = d;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (m_in_ready && m_out_valid) excl_ok = 1'b0;
            if (m_done) begin
                done_c = c;
                tmo = 1'b0;
                break;
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            if (m_in_ready) begin
                in_valid = 1'b1;
                for (int i = 0; i < 16; i++)
                    in_data[127-8*i -: 8] = (i < bb && ipos + i < len) ? msg[ipos+i] : 8'hee;
                ipos += bb;
            end
            if (stalled > 0 && stalled < stall_len && !m_out_valid) stall_ok = 1'b0;
            if (m_out_valid) begin
                if (nbeats == stall_beat && stalled < stall_len) begin
                    if (stalled == 0) begin
                        snap_d = m_out_data;
                        snap_n = m_out_nbytes;
                    end else if (m_out_data !== snap_d || m_out_nbytes !== snap_n) begin
                        stall_ok = 1'b0;
                    end
                    stalled++;
                end else begin
                    if (stalled > 0 && nbeats == stall_beat && (m_out_data !== snap_d || m_out_nbytes !== snap_n))
                        stall_ok = 1'b0;
                    out_ready = 1'b1;
                    got_nb[nbeats] = int'(m_out_nbytes);
                    for (int i = 0; i < 16; i++) begin
                        if (i < int'(m_out_nbytes)) got_out[opos+i] = m_out_data[127-8*i -: 8];
                        else if (m_out_data[127-8*i -: 8] !== 8'h00) zero_ok = 1'b0;
                    end
                    opos += int'(m_out_nbytes);
                    nbeats++;
                    last_out_c = c;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_a); end
        n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_checks++; if (out_data_a !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data_a); end
        n_checks++; if (out_nbytes_a !== 8'h0) begin n_fail++; $display("FAIL reset_out_nbytes: got %0d expected 0", out_nbytes_a); end
        n_checks++; if (state_out_a !== 320'h0) begin n_fail++; $display("FAIL reset_state_out: got %h expected 0", state_out_a); end
        n_checks++; if (busy_b !== 1'b0 || in_ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_b: got busy %b in_ready %b expected 0 0", busy_b, in_ready_b); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty;
        run_msg(1'b0, 320'h0, 0, 1'b0, -1, 0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL empty_timeout: got timeout %b expected 0", tmo); end
        n_checks++; if (done_c != 0) begin n_fail++; $display("FAIL empty_done_latency: got %0d expected 0", done_c); end
        n_checks++; if (nbeats != 0) begin n_fail++; $display("FAIL empty_beats: got %0d expected 0", nbeats); end
        n_checks++; if (state_out_a !== {64'h8000000000000000, 256'h0}) begin n_fail++; $display("FAIL empty_state: got %h expected 8000..0", state_out_a); end
    endtask

    task automatic test_one_byte;
        msg[0] = 8'h00;
        run_msg(1'b0, 320'h0, 1, 1'b0, -1, 0);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL one_timeout: got timeout %b expected 0", tmo); end
        n_checks++; if (nbeats != 1 || got_nb[0] != 1) begin n_fail++; $display("FAIL one_beats: got %0d beats nbytes %0d expected 1 1", nbeats, got_nb[0]); end
        n_checks++; if (got_out[0] !== 8'h00 || zero_ok !== 1'b1) begin n_fail++; $display("FAIL one_data: got %h zero_ok %b expected 00 1", got_out[0], zero_ok); end
        n_checks++; if (state_out_a !== {64'h0080000000000000, 256'h0}) begin n_fail++; $display("FAIL one_state: got %h expected 0080..0", state_out_a); end
        n_checks++; if (done_c - last_out_c != 1) begin n_fail++; $display("FAIL one_done_latency: got %0d expected 1", done_c - last_out_c); end
    endtask

    task automatic test_kat64;
        for (int i = 0; i < 33; i++) msg[i] = 8'(i);
        ref_run(ST64, 33, 1'b0, 8, 6);
        run_msg(1'b0, ST64, 33, 1'b0, -1, 0);
        n_checks++; if (tmo !== 1'b0 || nbeats != 5) begin n_fail++; $display("FAIL kat64_beats: got %0d beats timeout %b expected 5 0", nbeats, tmo); end
        n_checks++; if (got_nb[0] != 8 || got_nb[1] != 8 || got_nb[2] != 8 || got_nb[3] != 8 || got_nb[4] != 1) begin
            n_fail++; $display("FAIL kat64_nbytes: got %0d %0d %0d %0d %0d expected 8 8 8 8 1", got_nb[0], got_nb[1], got_nb[2], got_nb[3], got_nb[4]);
        end
        for (int i = 0; i < 33; i++) begin
            n_checks++; if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL kat64_ct[%0d]: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        n_checks++; if (state_out_a !== exp_state) begin n_fail++; $display("FAIL kat64_state: got %h expected %h", state_out_a, exp_state); end
        n_checks++; if (done_c - last_out_c != 1 || zero_ok !== 1'b1 || excl_ok !== 1'b1) begin
            n_fail++; $display("FAIL kat64_timing: got latency %0d zero_ok %b excl_ok %b expected 1 1 1", done_c - last_out_c, zero_ok, excl_ok);
        end
        for (int i = 0; i < 33; i++) ct[i] = exp_out[i];
        enc_state = exp_state;
        for (int i = 0; i < 33; i++) msg[i] = ct[i];
        run_msg(1'b0, ST64, 33, 1'b1, -1, 0);
        n_checks++; if (tmo !== 1'b0 || nbeats != 5) begin n_fail++; $display("FAIL dec64_beats: got %0d beats timeout %b expected 5 0", nbeats, tmo); end
        for (int i = 0; i < 33; i++) begin
            n_checks++; if (got_out[i] !== 8'(i)) begin n_fail++; $display("FAIL dec64_pt[%0d]: got %h expected %h", i, got_out[i], 8'(i)); end
        end
        n_checks++; if (state_out_a !== enc_state) begin n_fail++; $display("FAIL dec64_state: got %h expected %h", state_out_a, enc_state); end
    endtask

    task automatic test_rate128;
        for (int i = 0; i < 32; i++) msg[i] = 8'h10 + 8'(i);
        ref_run(ST128, 32, 1'b0, 16, 8);
        run_msg(1'b1, ST128, 32, 1'b0, -1, 0);
        n_checks++; if (tmo !== 1'b0 || nbeats != 2 || got_nb[0] != 16 || got_nb[1] != 16) begin
            n_fail++; $display("FAIL r128_beats: got %0d beats (%0d,%0d) timeout %b expected 2 (16,16) 0", nbeats, got_nb[0], got_nb[1], tmo);
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++; if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL r128_ct[%0d]: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        n_checks++; if (state_out_b !== exp_state) begin n_fail++; $display("FAIL r128_state: got %h expected %h", state_out_b, exp_state); end
        n_checks++; if (done_c - last_out_c != 9) begin n_fail++; $display("FAIL r128_done_latency: got %0d expected 9", done_c - last_out_c); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 33; i++) msg[i] = 8'(i);
        ref_run(ST64, 33, 1'b0, 8, 6);
        run_msg(1'b0, ST64, 33, 1'b0, 2, 5);
        n_checks++; if (stall_ok !== 1'b1 || excl_ok !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got stall_ok %b excl_ok %b expected 1 1", stall_ok, excl_ok); end
        n_checks++; if (tmo !== 1'b0 || nbeats != 5) begin n_fail++; $display("FAIL bp_beats: got %0d timeout %b expected 5 0", nbeats, tmo); end
        for (int i = 0; i < 33; i++) begin
            n_checks++; if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL bp_ct[%0d]: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        n_checks++; if (state_out_a !== exp_state) begin n_fail++; $display("FAIL bp_state: got %h expected %h", state_out_a, exp_state); end
    endtask

    task automatic test_reset_mid;
        bit quiet;
        for (int i = 0; i < 24; i++) msg[i] = 8'(3 * i + 1);
        ref_run(ST64, 24, 1'b0, 8, 6);
        @(negedge clk);
        use_b = 1'b0; state_in = ST64; msg_len = 24; dec = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 20 && !in_ready_a; c++) @(negedge clk);
        n_checks++; if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready_a); end
        in_valid = 1'b1;
        in_data = {msg[0], msg[1], msg[2], msg[3], msg[4], msg[5], msg[6], msg[7], 64'h0};
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !out_valid_a; c++) @(negedge clk);
        n_checks++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 1", out_valid_a); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_perm: got %b expected 1", busy_a); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b0 || in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ctrl: got busy %b in_ready %b out_valid %b done %b expected 0 0 0 0", busy_a, in_ready_a, out_valid_a, done_a);
        end
        n_checks++; if (out_data_a !== 64'h0 || out_nbytes_a !== 8'h0 || state_out_a !== 320'h0) begin
            n_fail++; $display("FAIL rmid_data: got out_data %h nbytes %0d state_out %h expected zeros", out_data_a, out_nbytes_a, state_out_a);
        end
        @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid_a !== 1'b0 || busy_a !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rmid_quiet: got quiet %b expected 1", quiet); end
        run_msg(1'b0, ST64, 24, 1'b0, -1, 0);
        n_checks++; if (tmo !== 1'b0 || nbeats != 3) begin n_fail++; $display("FAIL rmid_beats: got %0d timeout %b expected 3 0", nbeats, tmo); end
        for (int i = 0; i < 24; i++) begin
            n_checks++; if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL rmid_ct[%0d]: got %h expected %h", i, got_out[i], exp_out[i]); end
        end
        n_checks++; if (state_out_a !== exp_state) begin n_fail++; $display("FAIL rmid_state: got %h expected %h", state_out_a, exp_state); end
        n_checks++; if (done_c - last_out_c != 7) begin n_fail++; $display("FAIL rmid_done_latency: got %0d expected 7", done_c - last_out_c); end
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; dec = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        msg_len = '0; state_in = '0; in_data = '0; use_b = 1'b0;
        for (int i = 0; i < 64; i++) msg[i] = 8'h00;
        test_reset;
        test_empty;
        test_one_byte;
        test_kat64;
        test_rate128;
        test_backpressure;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
